// File: rtl/camera_power_sequencer.sv
// camera_power_sequencer
//   Drives the OV7670 power-up sequence after the system reset is released:
//   hold PWDN, pulse RESET# low, wait for the sensor to settle, then request
//   SCCB configuration. Capture is enabled only once configuration completes.
//   Failed or timed-out configuration is retried up to MAX_RETRIES times,
//   after which a fault is latched until restart or reset.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   restart      synchronous pulse; restarts the whole sequence from PWDN
//   cfg_done     SCCB block reports configuration finished OK
//   cfg_error    SCCB block reports NACK / abort
//   cam_pwdn     camera power-down pin, active-high (register output)
//   cam_resetn   camera reset pin, active-low (register output)
//   cfg_start    one-cycle configuration request per attempt
//   capture_en   high only in READY
//   seq_done     high only in READY
//   seq_fault    high only in FAULT
//   retry_count  configuration retries consumed
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PWDN     | camera powered down, in reset
// RST_LOW  | powered up, RESET# held low
// SETTLE   | RESET# released, waiting for sensor to settle
// CFG_REQ  | single cycle: cfg_start high, timeout counter loaded
// CFG_WAIT | waiting for cfg_done / cfg_error / timeout
// READY    | configured, capture enabled
// FAULT    | retries exhausted, latched until restart or reset

module camera_power_sequencer #(
   parameter int unsigned PWDN_CYCLES        = 100000,
   parameter int unsigned RESET_LOW_CYCLES   = 100000,
   parameter int unsigned SETTLE_CYCLES      = 100000,
   parameter int unsigned CFG_TIMEOUT_CYCLES = 10000000,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic       cfg_done,
   input  logic       cfg_error,
   output logic       cam_pwdn,
   output logic       cam_resetn,
   output logic       cfg_start,
   output logic       capture_en,
   output logic       seq_done,
   output logic       seq_fault,
   output logic [2:0] retry_count
);

   typedef enum logic [2:0] {
      S_PWDN,
      S_RST_LOW,
      S_SETTLE,
      S_CFG_REQ,
      S_CFG_WAIT,
      S_READY,
      S_FAULT
   } state_t;

   // Timed states run for N cycles: load N-1, count down, leave after zero.
   localparam logic [31:0] PWDN_LOAD    = 32'(PWDN_CYCLES - 1);
   localparam logic [31:0] RST_LOW_LOAD = 32'(RESET_LOW_CYCLES - 1);
   localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LOAD = 32'(CFG_TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [2:0]  retry_nxt;
   logic        cnt_zero;
   logic        pwdn_nxt, resetn_nxt, start_nxt, capture_nxt, done_nxt, fault_nxt;

   assign cnt_zero = (cnt == 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_PWDN;
         cnt         <= PWDN_LOAD;
         retry_count <= 3'd0;
         cam_pwdn    <= 1'b1;
         cam_resetn  <= 1'b0;
         cfg_start   <= 1'b0;
         capture_en  <= 1'b0;
         seq_done    <= 1'b0;
         seq_fault   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry_count <= retry_nxt;
         cam_pwdn    <= pwdn_nxt;
         cam_resetn  <= resetn_nxt;
         cfg_start   <= start_nxt;
         capture_en  <= capture_nxt;
         seq_done    <= done_nxt;
         seq_fault   <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_count;

      if (restart) begin
         state_nxt = S_PWDN;
         cnt_nxt   = PWDN_LOAD;
         retry_nxt = 3'd0;
      end else begin
         unique case (state)
            S_PWDN: begin
               if (cnt_zero) begin
                  state_nxt = S_RST_LOW;
                  cnt_nxt   = RST_LOW_LOAD;
               end else begin
                  cnt_nxt = cnt - 32'd1;
               end
            end
            S_RST_LOW: begin
               if (cnt_zero) begin
                  state_nxt = S_SETTLE;
                  cnt_nxt   = SETTLE_LOAD;
               end else begin
                  cnt_nxt = cnt - 32'd1;
               end
            end
            S_SETTLE: begin
               if (cnt_zero) begin
                  state_nxt = S_CFG_REQ;
               end else begin
                  cnt_nxt = cnt - 32'd1;
               end
            end
            S_CFG_REQ: begin
               state_nxt = S_CFG_WAIT;
               cnt_nxt   = TIMEOUT_LOAD;
            end
            S_CFG_WAIT: begin
               // cfg_done takes precedence over a simultaneous error
               if (cfg_done) begin
                  state_nxt = S_READY;
               end else if (cfg_error || cnt_zero) begin
                  if (retry_count < RETRY_MAX) begin
                     retry_nxt = retry_count + 3'd1;
                     state_nxt = S_CFG_REQ;
                  end else begin
                     state_nxt = S_FAULT;
                  end
               end else begin
                  cnt_nxt = cnt - 32'd1;
               end
            end
            S_READY: state_nxt = S_READY;
            S_FAULT: state_nxt = S_FAULT;
            default: begin
               state_nxt = S_PWDN;
               cnt_nxt   = PWDN_LOAD;
               retry_nxt = 3'd0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so every pin is
   // a flop output and tracks the state register cycle for cycle.
   always_comb begin
      pwdn_nxt    = 1'b0;
      resetn_nxt  = 1'b1;
      start_nxt   = 1'b0;
      capture_nxt = 1'b0;
      done_nxt    = 1'b0;
      fault_nxt   = 1'b0;
      unique case (state_nxt)
         S_PWDN: begin
            pwdn_nxt   = 1'b1;
            resetn_nxt = 1'b0;
         end
         S_RST_LOW:  resetn_nxt = 1'b0;
         S_SETTLE:   resetn_nxt = 1'b1;
         S_CFG_REQ:  start_nxt  = 1'b1;
         S_CFG_WAIT: resetn_nxt = 1'b1;
         S_READY: begin
            capture_nxt = 1'b1;
            done_nxt    = 1'b1;
         end
         S_FAULT:    fault_nxt  = 1'b1;
         default: begin
            pwdn_nxt   = 1'b1;
            resetn_nxt = 1'b0;
         end
      endcase
   end

endmodule
